counter_cmd_sequencer: RTL and testbench

//  Synthesizable command front-end for universal_binary_counter; replaces hand-toggled control stimulus.

---
 rtl/counter_cmd_sequencer_pkg.sv | 24 ++
 rtl/counter_cmd_sequencer.sv | 113 +++++++++++
 tb/tb_counter_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_cmd_sequencer_pkg.sv
// Purpose: shared opcodes, FSM state encoding and helpers for counter_cmd_sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_cmd_sequencer_pkg;

    localparam logic [1:0] OP_CLR    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_RUN_UP = 2'b10;
    localparam logic [1:0] OP_RUN_DN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Both RUN opcodes share the upper bit; the lower bit selects direction.
    function automatic logic is_run_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/counter_cmd_sequencer.sv
// Purpose: command front-end driving a universal binary counter (CLR/LOAD/RUN_UP/RUN_DN), RUN saturates at the limit.
// Latency: CLR/LOAD pulse at accept+1, done at accept+2; RUN of S steps en at accept+1..accept+S, done at accept+S+1 (arg 0: accept+2).
// Backpressure: cmd_ready only in IDLE; commands offered while busy are not queued and must be held upstream.
module counter_cmd_sequencer
    import counter_cmd_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_arg,
    output logic         syn_clr,
    output logic         load,
    output logic         en,
    output logic         up,
    output logic [N-1:0] d,
    input  logic         max_tick,
    input  logic         min_tick,
    output logic         busy,
    output logic         done,
    output logic         hit_limit
);

    localparam logic [N-1:0] ONE = N'(1);

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   remaining;
    logic           hit_q;
    logic           accept;
    logic           rem_zero;
    logic           rem_last;
    logic           at_limit;

    assign accept   = cmd_valid && (state == S_IDLE);
    assign rem_zero = (remaining == '0);
    assign rem_last = (remaining == ONE);
    // The counter already sits at the end it is heading toward.
    assign at_limit = (up && max_tick) || (!up && min_tick);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latches, step counter and the registered early-stop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            d         <= '0;
            up        <= 1'b0;
            remaining <= '0;
            hit_q     <= 1'b0;
        end else begin
            if (accept && (cmd_op == OP_LOAD)) begin
                d <= cmd_arg;
            end
            if (accept && is_run_op(cmd_op)) begin
                remaining <= cmd_arg;
                up        <= (cmd_op == OP_RUN_UP);
            end else if (en) begin
                remaining <= remaining - ONE;
            end
            // Only a RUN that stops with steps still owed reports a limit hit;
            // the flag is therefore high exactly in the following DONE cycle.
            hit_q <= (state == S_RUN) && !rem_zero && at_limit;
        end
    end

    // Next-state logic. The final step of a RUN goes straight to DONE so done
    // lands one cycle after the last en.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_CLR:  state_nxt = S_CLR;
                        OP_LOAD: state_nxt = S_LOAD;
                        default: state_nxt = S_RUN;
                    endcase
                end
            end
            S_CLR:  state_nxt = S_DONE;
            S_LOAD: state_nxt = S_DONE;
            S_RUN: begin
                if (rem_zero || at_limit || rem_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; en never fires at the limit, so the counter cannot wrap.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        syn_clr   = (state == S_CLR);
        load      = (state == S_LOAD);
        en        = (state == S_RUN) && !rem_zero && !at_limit;
        done      = (state == S_DONE);
        hit_limit = hit_q;
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
module tb_counter_cmd_sequencer;
    import counter_cmd_sequencer_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [N-1:0] cmd_arg = '0;
    logic         syn_clr, load, en, up;
    logic [N-1:0] d;
    logic         max_tick, min_tick;
    logic         busy, done, hit_limit;

    // Behavioural stand-in for universal_binary_counter.
    logic [N-1:0] q;
    assign max_tick = (q == {N{1'b1}});
    assign min_tick = (q == '0);
    always @(posedge clk) begin
        if (reset)        q <= '0;
        else if (syn_clr) q <= '0;
        else if (load)    q <= d;
        else if (en)      q <= up ? q + 8'd1 : q - 8'd1;
    end

    counter_cmd_sequencer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .syn_clr   (syn_clr),
        .load      (load),
        .en        (en),
        .up        (up),
        .d         (d),
        .max_tick  (max_tick),
        .min_tick  (min_tick),
        .busy      (busy),
        .done      (done),
        .hit_limit (hit_limit)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Every cycle: at most one control pin high, busy is the inverse of cmd_ready.
    always @(negedge clk) begin
        if (mon_on) begin
            n_vec++;
            if (($countones({syn_clr, load, en}) > 1) || (busy === cmd_ready)) begin
                n_err++;
                $display("FAIL monitor: syn_clr=%b load=%b en=%b busy=%b cmd_ready=%b at %0t",
                         syn_clr, load, en, busy, cmd_ready, $time);
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        int         n_clr;
        int         n_ld;
        int         n_en;
        logic [7:0] q;
        int         hit;
        int         lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic run_cmd(input vec_t v, input int idx);
        int c_clr = 0;
        int c_ld  = 0;
        int c_en  = 0;
        int lat   = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_arg   = v.arg;
        check($sformatf("v%0d_ready_before", idx), int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_arg   = ~v.arg;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) @(negedge clk);
            c_clr += int'(syn_clr);
            c_ld  += int'(load);
            c_en  += int'(en);
            if (done) begin
                lat = c;
                break;
            end
        end
        check($sformatf("v%0d_done_latency", idx), lat, v.lat);
        if (lat > 0) begin
            check($sformatf("v%0d_syn_clr_cycles", idx), c_clr, v.n_clr);
            check($sformatf("v%0d_load_cycles", idx), c_ld, v.n_ld);
            check($sformatf("v%0d_en_cycles", idx), c_en, v.n_en);
            check($sformatf("v%0d_q", idx), int'(q), int'(v.q));
            check($sformatf("v%0d_hit_limit", idx), int'(hit_limit), v.hit);
            if (v.op == OP_LOAD)
                check($sformatf("v%0d_d", idx), int'(d), int'(v.arg));
            if (is_run_op(v.op))
                check($sformatf("v%0d_up", idx), int'(up), (v.op == OP_RUN_UP) ? 1 : 0);
            @(negedge clk);
            check($sformatf("v%0d_done_width", idx), int'(done), 0);
            check($sformatf("v%0d_ready_after", idx), int'(cmd_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int c_en;
        int c_ld;
        bit got20;

        //          op         arg    clr ld en  q      hit lat
        vecs[0]  = '{OP_LOAD,   8'h9A, 0, 1, 0, 8'h9A, 0, 2};
        vecs[1]  = '{OP_RUN_UP, 8'h05, 0, 0, 5, 8'h9F, 0, 6};
        vecs[2]  = '{OP_LOAD,   8'hFC, 0, 1, 0, 8'hFC, 0, 2};
        vecs[3]  = '{OP_RUN_UP, 8'h0A, 0, 0, 3, 8'hFF, 1, 5};
        vecs[4]  = '{OP_CLR,    8'h77, 1, 0, 0, 8'h00, 0, 2};
        vecs[5]  = '{OP_RUN_DN, 8'h01, 0, 0, 0, 8'h00, 1, 2};
        vecs[6]  = '{OP_RUN_UP, 8'h01, 0, 0, 1, 8'h01, 0, 2};
        vecs[7]  = '{OP_LOAD,   8'h02, 0, 1, 0, 8'h02, 0, 2};
        vecs[8]  = '{OP_RUN_DN, 8'h05, 0, 0, 2, 8'h00, 1, 4};
        vecs[9]  = '{OP_LOAD,   8'hFF, 0, 1, 0, 8'hFF, 0, 2};
        vecs[10] = '{OP_RUN_DN, 8'h03, 0, 0, 3, 8'hFC, 0, 4};

        // Reset for two edges, then check every output's reset value.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy",      int'(busy), 0);
        check("rst_syn_clr",   int'(syn_clr), 0);
        check("rst_load",      int'(load), 0);
        check("rst_en",        int'(en), 0);
        check("rst_up",        int'(up), 0);
        check("rst_d",         int'(d), 0);
        check("rst_done",      int'(done), 0);
        check("rst_hit_limit", int'(hit_limit), 0);
        reset  = 1'b0;
        mon_on = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_cmd(vecs[i], i);
        end

        // RUN_UP 0 with a LOAD 0x55 held valid throughout: the LOAD must wait for cmd_ready.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN_UP;
        cmd_arg   = 8'h00;
        check("hold_ready_before", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_op  = OP_LOAD;
        cmd_arg = 8'h55;
        c_en = int'(en);
        c_ld = int'(load);
        check("hold_c1_ready", int'(cmd_ready), 0);
        check("hold_c1_done",  int'(done), 0);
        @(negedge clk);
        c_en += int'(en);
        c_ld += int'(load);
        check("hold_c2_ready", int'(cmd_ready), 0);
        check("hold_c2_done",  int'(done), 1);
        check("hold_c2_hit",   int'(hit_limit), 0);
        @(negedge clk);
        c_ld += int'(load);
        check("hold_run0_en_cycles", c_en, 0);
        check("hold_c3_ready", int'(cmd_ready), 1);
        check("hold_no_early_load", c_ld, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_c4_load",  int'(load), 1);
        check("hold_c4_d",     int'(d), 'h55);
        @(negedge clk);
        check("hold_c5_done",  int'(done), 1);
        check("hold_c5_q",     int'(q), 'h55);

        // Long RUN aborted by reset after 20 en cycles.
        run_cmd('{OP_CLR, 8'h00, 1, 0, 0, 8'h00, 0, 2}, 99);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN_UP;
        cmd_arg   = 8'd200;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        c_en  = 0;
        got20 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            c_en += int'(en);
            if (c_en == 20) begin
                got20 = 1'b1;
                break;
            end
        end
        check("abort_reached_20_en", int'(got20), 1);
        check("abort_q_at_20th_en", int'(q), 19);
        reset = 1'b1;
        @(negedge clk);
        check("abort_en",        int'(en), 0);
        check("abort_cmd_ready", int'(cmd_ready), 1);
        check("abort_done",      int'(done), 0);
        check("abort_hit",       int'(hit_limit), 0);
        check("abort_up",        int'(up), 0);
        reset = 1'b0;
        c_en = 0;
        c_ld = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            c_ld += int'(done);
            c_en += int'(en);
        end
        check("abort_no_done_after", c_ld, 0);
        check("abort_no_en_after",   c_en, 0);

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
